// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes it into instruction
// memory, fills the remaining words with NOP and keeps the core in reset until the image is complete.
module imem_loader #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // state | meaning
  // IDLE  | after reset, core held in reset
  // LEN0  | waiting for word count low byte
  // LEN1  | waiting for word count high byte
  // DATA  | assembling and writing image words
  // FILL  | writing NOP to addresses N..DEPTH-1
  // DONE  | image loaded, core released
  // ERR   | header length exceeded DEPTH
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_FILL, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0]   DEPTH_LEN = 16'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nx;
  logic [15:0]       len, len_nx;
  logic [ADDR_W:0]   word_cnt, word_cnt_nx;
  logic [ADDR_W:0]   fill_addr, fill_addr_nx;
  logic [1:0]        byte_idx, byte_idx_nx;
  logic [23:0]       asm_q, asm_nx;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       wdata_nx;
  logic              xfer;
  logic [15:0]       len_hdr;

  assign xfer    = in_valid && in_ready;
  assign len_hdr = {in_data, len[7:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      fill_addr  <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      len        <= len_nx;
      word_cnt   <= word_cnt_nx;
      fill_addr  <= fill_addr_nx;
      byte_idx   <= byte_idx_nx;
      asm_q      <= asm_nx;
      imem_we    <= we_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      // Status outputs are registered copies of the state being entered.
      in_ready   <= (state_nx == S_LEN0) || (state_nx == S_LEN1) || (state_nx == S_DATA);
      cpu_reset  <= (state_nx != S_DONE);
      busy       <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                    (state_nx == S_DATA) || (state_nx == S_FILL);
      done       <= (state_nx == S_DONE);
      error      <= (state_nx == S_ERR);
    end
  end

  always_comb begin
    state_nx     = state;
    len_nx       = len;
    word_cnt_nx  = word_cnt;
    fill_addr_nx = fill_addr;
    byte_idx_nx  = byte_idx;
    asm_nx       = asm_q;
    we_nx        = 1'b0;
    addr_nx      = imem_addr;
    wdata_nx     = imem_wdata;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nx = S_LEN0;
      end
      S_LEN0: begin
        if (xfer) begin
          len_nx   = {len[15:8], in_data};
          state_nx = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_nx = len_hdr;
          if (len_hdr > DEPTH_LEN) begin
            state_nx = S_ERR;
          end else if (len_hdr == 16'd0) begin
            fill_addr_nx = '0;
            state_nx     = S_FILL;
          end else begin
            word_cnt_nx = '0;
            byte_idx_nx = 2'd0;
            state_nx    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_idx_nx = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: asm_nx[7:0]   = in_data;
            2'd1: asm_nx[15:8]  = in_data;
            2'd2: asm_nx[23:16] = in_data;
            default: begin
              we_nx       = 1'b1;
              addr_nx     = word_cnt[ADDR_W-1:0];
              wdata_nx    = {in_data, asm_q};
              word_cnt_nx = word_cnt + 1'b1;
              if (16'(word_cnt) + 16'd1 == len) begin
                fill_addr_nx = len[ADDR_W:0];
                state_nx     = S_FILL;
              end
            end
          endcase
        end
      end
      S_FILL: begin
        // fill_addr reaching DEPTH also covers a full image (N == DEPTH) with no NOP writes.
        if (fill_addr == DEPTH_A) begin
          state_nx = S_DONE;
        end else begin
          we_nx        = 1'b1;
          addr_nx      = fill_addr[ADDR_W-1:0];
          wdata_nx     = NOP_WORD;
          fill_addr_nx = fill_addr + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware boot loader that writes a program image into the RISCVCPU instruction memory from a byte stream. It receives a length header and little-endian instruction bytes over a valid/ready interface, drives the instruction memory write port, and pads every unloaded word with NOP (0x00000013). It holds the core in reset until the image is complete. It sits between the external download link and `RISCVCPU` and replaces direct memory preloading for on-chip program download.

## Interface
- `DEPTH`, 256: instruction memory size in 32-bit words.
- `ADDR_W`, 8: word-address width; must satisfy 2^ADDR_W >= DEPTH.
- `NOP_WORD`, 32'h00000013: fill value (`addi x0,x0,0`).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  a byte is offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `imem_we`  out  1  instruction memory write strobe, one word per asserted cycle.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word data.
- `cpu_reset`  out  1  active-high reset to `RISCVCPU`.
- `busy`  out  1  a load is in progress (states LEN0 through FILL).
- `done`  out  1  image loaded and core released.
- `error`  out  1  header length exceeded `DEPTH`.

## Operation
- Stream format:
  - byte 0 and byte 1 are word count N, 16-bit little-endian;
  - these are followed by 4*N instruction bytes, least significant byte first, for words 0..N-1.
- FSM states: IDLE, LEN0, LEN1, DATA, FILL, DONE, ERR. All outputs are registered.
- IDLE: `in_ready`=0, `cpu_reset`=1. `start` moves to LEN0.
- LEN0: `in_ready`=1. A transfer latches `len[7:0]` and moves to LEN1.
- LEN1: `in_ready`=1. A transfer latches `len[15:8]`, then branches:
  - N > DEPTH: move to ERR;
  - N == 0: move to FILL with fill address 0;
  - otherwise: move to DATA with word counter 0 and byte index 0.
- DATA: `in_ready`=1.
  - Each transfer shifts the byte into lane `byte_idx` of the assembly register; `byte_idx` wraps 3 to 0.
  - On the edge that accepts lane 3, the loader registers `imem_we`=1, `imem_addr`=word counter and `imem_wdata`={byte3..byte0}, then increments the word counter.
  - When the accepted word is word N-1, the next state is FILL with fill address N.
- FILL: `in_ready`=0. One write of `NOP_WORD` per cycle at addresses N..DEPTH-1. After address DEPTH-1 the next state is DONE. If N == DEPTH, FILL performs zero writes and passes straight to DONE.
- DONE: `done`=1, `cpu_reset`=0, `in_ready`=0. `start` moves to LEN0; `cpu_reset`=1 and `done`=0 from that edge.
- ERR: `error`=1, `cpu_reset`=1, no memory writes. `start` moves to LEN0 and clears `error`. Bytes offered in ERR are not accepted.
- `start` asserted in LEN0, LEN1, DATA or FILL is ignored.
- Arithmetic: the word counter and fill address are ADDR_W+1 bits wide so that DEPTH is representable. `len` is compared as 16-bit unsigned.

## Timing
- Reset values of all outputs: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0. The state returns to IDLE.
- Reset assertion mid-load takes effect immediately. No further writes occur, and the partially written memory is left as is.
- `start` at edge t gives `in_ready`=1 after edge t.
- Write latency: `imem_we` is high in the cycle following the acceptance of each word's fourth byte.
- `in_ready` stays high through DATA, including the write cycle, so a back-to-back stream sustains 1 byte per cycle. `in_valid` gaps stall the loader without loss.
- Minimum load time for an unstalled stream, from `start` to `done`: 1 + 2 + 4N + (DEPTH−N) + 1 cycles.
- `imem_we` is never asserted in IDLE, LEN0, LEN1, DONE or ERR, except for the trailing write of word N-1, which occurs in the first FILL cycle.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `in_valid`=1. Required: every output at its reset value, and no `in_ready`.
- Program load: send N=7 followed by the while-sum words 00000093, 00000113, 04100193, 002080b3, 00110113, 00310663, 00c00067. Required:
  - IMem[0..6] equal those words and IMem[7..255] = 00000013;
  - `done`=1 exactly 1+2+28+249+1 cycles after `start`;
  - with `RISCVCPU` attached, x1 = 2080 after 2000 further cycles.
- Backpressure: repeat the program load with `in_valid` low on every other cycle. Required: identical memory contents, no dropped or duplicated bytes, and the word count of `imem_we` pulses equals 256.
- Empty image: N=0. Required: 256 writes of 00000013 at addresses 0..255, then `done`=1.
- Oversize: N=257. Required:
  - `error`=1 after the second header byte, with zero `imem_we` pulses and `cpu_reset` held at 1;
  - a subsequent `start` followed by N=1 with word 00000093 completes with `done`=1 and `error`=0.
- Mid-load reset: assert `reset` after 10 data bytes. Required: immediate return to IDLE with reset output values, and no writes after reset.
